inst_fetch_queue: RTL

Parametrised instruction fetcher sitting between the MemoryController and the Decoder. It keeps the PC, issues one word fetch at a time, and predicts next-PC for JAL and, optionally, for backward conditional branches. Fetched instructions are buffered in a QUEUE_DEPTH-entry FIFO with a valid/ready handshake to the Decoder. A ROB redirect flushes the queue and any in-flight fetch.

---
 rtl/inst_fetch_queue_pkg.sv | 25 ++
 rtl/inst_fetch_queue_fifo.sv | 48 ++++
 rtl/inst_fetch_queue.sv | 110 +++++++++++
 3 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants, FSM state type and RISC-V immediate helpers for the fetch queue.
package inst_fetch_queue_pkg;

  localparam int          WORD_MSB      = 31;
  localparam logic [31:0] ZERO_WORD     = 32'h0;
  localparam logic        TRUE          = 1'b1;
  localparam logic        FALSE         = 1'b0;
  localparam logic [6:0]  JAL_OPCODE    = 7'b1101111;
  localparam logic [6:0]  BRANCH_OPCODE = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAITING = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Circular buffer with push/pop/clear; clear wins over push and pop.
module fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  always_ff @(posedge clk) begin
    if (push && !clear) mem[tail] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[head];
  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetcher: one outstanding word fetch, static next-PC prediction, decoder FIFO.
//   state   | meaning
//   IDLE    | may issue a fetch when the queue has room
//   WAITING | fetch outstanding, response will be queued
//   DISCARD | fetch outstanding but flushed, response will be dropped
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int          QUEUE_DEPTH    = 8,
  parameter int          PREDICT_BRANCH = 1,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mc_ready_in,
  input  logic [31:0] mc_instruction_in,
  output logic        mc_request_signal_out,
  output logic [31:0] mc_address_out,
  output logic        dec_valid_out,
  input  logic        dec_ready_in,
  output logic [31:0] dec_inst_out,
  output logic [31:0] dec_pc_out,
  output logic        dec_pred_taken_out,
  input  logic        rob_clear_in,
  input  logic [31:0] rob_pc_in
);

  localparam int EW = 2 * (WORD_MSB + 1) + 1;
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t  state;
  logic [31:0]   pc;
  logic [31:0]   next_pc;
  logic          next_pred;
  logic          q_push;
  logic          q_pop;
  logic          q_empty;
  logic          q_full;
  logic [CW-1:0] q_count;
  logic [EW-1:0] q_head;

  always_comb begin
    next_pc   = pc + 32'd4;
    next_pred = FALSE;
    if (mc_instruction_in[6:0] == JAL_OPCODE) begin
      next_pc   = pc + imm_j(mc_instruction_in);
      next_pred = TRUE;
    end else if ((PREDICT_BRANCH != 0) && (mc_instruction_in[6:0] == BRANCH_OPCODE)
                 && mc_instruction_in[31]) begin
      next_pc   = pc + imm_b(mc_instruction_in);
      next_pred = TRUE;
    end
  end

  assign q_push = (state == WAITING) && mc_ready_in && !rob_clear_in;
  assign q_pop  = dec_valid_out && dec_ready_in && !rob_clear_in;

  fetch_fifo #(.WIDTH(EW), .DEPTH(QUEUE_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .pop       (q_pop),
    .clear     (rob_clear_in),
    .push_data ({mc_instruction_in, pc, next_pred}),
    .head_data (q_head),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      pc                    <= RESET_PC;
      mc_request_signal_out <= FALSE;
      mc_address_out        <= ZERO_WORD;
    end else begin
      mc_request_signal_out <= FALSE;
      if (rob_clear_in) begin
        pc    <= rob_pc_in;
        state <= (state == WAITING && !mc_ready_in) ? DISCARD : IDLE;
      end else begin
        case (state)
          IDLE: if (!q_full) begin
            mc_request_signal_out <= TRUE;
            mc_address_out        <= pc;
            state                 <= WAITING;
          end
          WAITING: if (mc_ready_in) begin
            pc    <= next_pc;
            state <= IDLE;
          end
          DISCARD: if (mc_ready_in) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Requests are gated on !full, so an overflowing push means the gating broke.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(q_push && q_count == CW'(QUEUE_DEPTH)));
  end

  assign dec_valid_out      = !q_empty;
  assign dec_inst_out       = q_empty ? ZERO_WORD : q_head[EW-1 -: 32];
  assign dec_pc_out         = q_empty ? ZERO_WORD : q_head[32:1];
  assign dec_pred_taken_out = q_empty ? FALSE : q_head[0];

endmodule
